// File: rtl/b_powermonitor_v2_00.sv
// rtl/b_powermonitor_v2_00.sv - rail fault/warn debounce, sticky status and power-good.
// Raw conditions are sampled once per scan; all outputs derive from registered state.
module b_powermonitor_v2_00 #(
  parameter int NumConverters = 8,
  parameter int PgoodConfig   = 0,
  parameter int FaultDebounce = 3,
  parameter int WarnDebounce  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     conv_done,
  input  logic [NumConverters-1:0] fault_raw,
  input  logic [NumConverters-1:0] warn_raw,
  input  logic [NumConverters-1:0] fault_mask,
  input  logic                     fault_clear,
  output logic                     fault,
  output logic                     warn,
  output logic                     eoc,
  output logic [31:0]              pgood_bus,
  output logic [31:0]              fault_status
);

  localparam int CntW = (NumConverters > 1) ? $clog2(NumConverters) : 1;
  localparam logic [CntW-1:0] LastRail = CntW'(NumConverters - 1);
  localparam logic [3:0] FaultLim = 4'(FaultDebounce);
  localparam logic [3:0] WarnLim  = 4'(WarnDebounce);

  logic [CntW-1:0]          scan_cnt_q, scan_cnt_d;
  logic                     eoc_q, eoc_d;
  logic                     valid_q, valid_d;
  logic [3:0]               fcnt_q [NumConverters];
  logic [3:0]               fcnt_d [NumConverters];
  logic [3:0]               wcnt_q [NumConverters];
  logic [3:0]               wcnt_d [NumConverters];
  logic [NumConverters-1:0] ffilt_q, ffilt_d;
  logic [NumConverters-1:0] wfilt_q, wfilt_d;
  logic [NumConverters-1:0] status_q, status_d;
  logic                     scan_end;

  always_comb begin
    scan_end   = conv_done && (scan_cnt_q == LastRail);
    scan_cnt_d = scan_cnt_q;
    if (conv_done) begin
      scan_cnt_d = scan_end ? '0 : scan_cnt_q + 1'b1;
    end
    eoc_d   = scan_end;
    valid_d = valid_q | scan_end;
    ffilt_d = ffilt_q;
    wfilt_d = wfilt_q;
    for (int i = 0; i < NumConverters; i++) begin
      fcnt_d[i] = fcnt_q[i];
      wcnt_d[i] = wcnt_q[i];
      if (scan_end) begin
        if (fault_raw[i]) fcnt_d[i] = (fcnt_q[i] >= FaultLim) ? FaultLim : fcnt_q[i] + 4'd1;
        else              fcnt_d[i] = 4'd0;
        if (warn_raw[i])  wcnt_d[i] = (wcnt_q[i] >= WarnLim) ? WarnLim : wcnt_q[i] + 4'd1;
        else              wcnt_d[i] = 4'd0;
        ffilt_d[i] = (fcnt_d[i] == FaultLim);
        wfilt_d[i] = (wcnt_d[i] == WarnLim);
      end
    end
    // Clear only drops rails whose filtered fault is gone; a concurrent set always wins.
    status_d = status_q;
    if (fault_clear) status_d = status_q & ffilt_d;
    status_d = status_d | (ffilt_d & ~fault_mask);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt_q <= '0;
      eoc_q      <= 1'b0;
      valid_q    <= 1'b0;
      ffilt_q    <= '0;
      wfilt_q    <= '0;
      status_q   <= '0;
      for (int i = 0; i < NumConverters; i++) begin
        fcnt_q[i] <= 4'd0;
        wcnt_q[i] <= 4'd0;
      end
    end else begin
      scan_cnt_q <= scan_cnt_d;
      eoc_q      <= eoc_d;
      valid_q    <= valid_d;
      ffilt_q    <= ffilt_d;
      wfilt_q    <= wfilt_d;
      status_q   <= status_d;
      for (int i = 0; i < NumConverters; i++) begin
        fcnt_q[i] <= fcnt_d[i];
        wcnt_q[i] <= wcnt_d[i];
      end
    end
  end

  assign fault = |status_q;
  assign warn  = |(wfilt_q & ~fault_mask);
  assign eoc   = eoc_q;

  always_comb begin
    fault_status                      = '0;
    fault_status[NumConverters-1:0]   = status_q;
    pgood_bus                         = '0;
    if (PgoodConfig == 1) begin
      if (valid_q) pgood_bus[NumConverters-1:0] = ~status_q;
    end else begin
      pgood_bus[0] = valid_q & ~(|status_q);
    end
  end

endmodule

// File: tb/tb_b_powermonitor_v2_00.sv
// tb/tb_b_powermonitor_v2_00.sv - scoreboard bench for b_powermonitor_v2_00.
// Rail-4 aggregated instance is scoreboarded on eoc; 32-rail bus instance is checked inline.
module tb_b_powermonitor_v2_00;

  typedef struct {
    logic [31:0] fs;
    logic        f;
    logic        w;
    logic [31:0] pg;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        cd_a, clr_a, cd_b, clr_b;
  logic [3:0]  fr_a, wr_a, mask_a;
  logic [31:0] fr_b, wr_b, mask_b;
  logic        f_a, w_a, eoc_a, f_b, w_b, eoc_b;
  logic [31:0] pg_a, fs_a, pg_b, fs_b;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  b_powermonitor_v2_00 #(.NumConverters(4)) dut_a (
    .clock(clock), .reset(reset), .conv_done(cd_a), .fault_raw(fr_a), .warn_raw(wr_a),
    .fault_mask(mask_a), .fault_clear(clr_a), .fault(f_a), .warn(w_a), .eoc(eoc_a),
    .pgood_bus(pg_a), .fault_status(fs_a)
  );

  b_powermonitor_v2_00 #(.NumConverters(32), .PgoodConfig(1)) dut_b (
    .clock(clock), .reset(reset), .conv_done(cd_b), .fault_raw(fr_b), .warn_raw(wr_b),
    .fault_mask(mask_b), .fault_clear(clr_b), .fault(f_b), .warn(w_b), .eoc(eoc_b),
    .pgood_bus(pg_b), .fault_status(fs_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && eoc_a) begin
      if (sb.size() == 0) begin
        chk("eoc_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("eoc_fault_status", fs_a, mon_e.fs);
        chk("eoc_fault", {31'd0, f_a}, {31'd0, mon_e.f});
        chk("eoc_warn", {31'd0, w_a}, {31'd0, mon_e.w});
        chk("eoc_pgood", pg_a, mon_e.pg);
      end
    end
  end

  task automatic strobe_a();
    cd_a = 1'b1;
    @(posedge clock); #1;
    cd_a = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic scan_a(input logic [3:0] fr, input logic [3:0] wr, input logic [31:0] efs,
                        input logic ef, input logic ew, input logic [31:0] epg);
    fr_a = fr;
    wr_a = wr;
    repeat (3) strobe_a();
    sb.push_back('{efs, ef, ew, epg});
    strobe_a();
  endtask

  task automatic scan_b(input logic [31:0] fr);
    fr_b = fr;
    repeat (32) begin
      cd_b = 1'b1;
      @(posedge clock); #1;
      cd_b = 1'b0;
    end
    @(posedge clock); #1;
  endtask

  task automatic pulse_clear_a();
    clr_a = 1'b1;
    @(posedge clock); #1;
    clr_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cd_a = 0; clr_a = 0; fr_a = '0; wr_a = '0; mask_a = '0;
    cd_b = 0; clr_b = 0; fr_b = '0; wr_b = '0; mask_b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_fault", {31'd0, f_a}, 32'd0);
    chk("rst_eoc", {31'd0, eoc_a}, 32'd0);
    chk("rst_pgood_a", pg_a, 32'd0);
    chk("rst_pgood_b", pg_b, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("pgood_before_scan", pg_a, 32'd0);

    scan_b(32'd0);
    chk("bus_pgood_clean", pg_b, 32'hFFFF_FFFF);
    scan_b(32'h8000_0000);
    scan_b(32'h8000_0000);
    chk("bus_pgood_debouncing", pg_b, 32'hFFFF_FFFF);
    scan_b(32'h8000_0000);
    chk("bus_pgood_rail31", pg_b, 32'h7FFF_FFFF);
    chk("bus_status_rail31", fs_b, 32'h8000_0000);
    chk("bus_fault", {31'd0, f_b}, 32'd1);

    scan_a(4'h0, 4'h0, 32'h0, 0, 0, 32'h1);
    scan_a(4'h4, 4'h1, 32'h0, 0, 0, 32'h1);
    scan_a(4'h0, 4'h1, 32'h0, 0, 1, 32'h1);
    scan_a(4'h4, 4'h0, 32'h0, 0, 0, 32'h1);
    scan_a(4'h4, 4'h0, 32'h0, 0, 0, 32'h1);
    scan_a(4'h4, 4'h0, 32'h4, 1, 0, 32'h0);
    scan_a(4'h0, 4'h0, 32'h4, 1, 0, 32'h0);

    pulse_clear_a();
    chk("clear_status", fs_a, 32'h0);
    chk("clear_fault", {31'd0, f_a}, 32'd0);
    chk("clear_pgood", pg_a, 32'h1);

    scan_a(4'h4, 4'h0, 32'h0, 0, 0, 32'h1);
    scan_a(4'h4, 4'h0, 32'h0, 0, 0, 32'h1);
    scan_a(4'h4, 4'h0, 32'h4, 1, 0, 32'h0);
    pulse_clear_a();
    chk("clear_persist_status", fs_a, 32'h4);
    chk("clear_persist_pgood", pg_a, 32'h0);

    mask_a = 4'h4;
    @(posedge clock); #1;
    chk("mask_keeps_status", fs_a, 32'h4);
    scan_a(4'h0, 4'h0, 32'h4, 1, 0, 32'h0);
    pulse_clear_a();
    chk("clear_under_mask", fs_a, 32'h0);

    repeat (5) scan_a(4'h4, 4'h4, 32'h0, 0, 0, 32'h1);
    mask_a = 4'h0;
    @(posedge clock); #1;
    chk("unmask_status", fs_a, 32'h4);
    chk("unmask_fault", {31'd0, f_a}, 32'd1);
    chk("unmask_warn", {31'd0, w_a}, 32'd1);

    fr_a = '0;
    wr_a = '0;
    strobe_a();
    strobe_a();
    reset = 1'b1;
    #2;
    chk("midrst_fault", {31'd0, f_a}, 32'd0);
    chk("midrst_warn", {31'd0, w_a}, 32'd0);
    chk("midrst_eoc", {31'd0, eoc_a}, 32'd0);
    chk("midrst_pgood", pg_a, 32'd0);
    chk("midrst_status", fs_a, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    scan_a(4'h0, 4'h0, 32'h0, 0, 0, 32'h1);

    repeat (4) @(posedge clock);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/b_powermonitor_v2_00.md
B_POWERMONITOR_V2_00 -- requirements
Module: b_powermonitor_v2_00

Interface
REQ-001 SHALL have parameter NumConverters, default 8, meaning number of monitored rails; legal range 1..32.
REQ-002 SHALL have parameter PgoodConfig, default 0, meaning 0 = single aggregated pgood and 1 = per-rail pgood bus.
REQ-003 SHALL have parameter FaultDebounce, default 3, meaning the count of consecutive scans (1..15) a fault condition must persist before it is recognised.
REQ-004 SHALL have parameter WarnDebounce, default 2, meaning the count of consecutive scans (1..15) a warn condition must persist before it is recognised.
REQ-005 SHALL have port clock, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port conv_done, input, 1 bit, a one-cycle strobe marking the end of one rail's ADC conversion.
REQ-008 SHALL have port fault_raw, input, NumConverters bits, per-rail unfiltered fault condition (level).
REQ-009 SHALL have port warn_raw, input, NumConverters bits, per-rail unfiltered warn condition (level).
REQ-010 SHALL have port fault_mask, input, NumConverters bits, where 1 excludes the rail from the fault and warn outputs.
REQ-011 SHALL have port fault_clear, input, 1 bit, a one-cycle strobe requesting a clear of latched faults.
REQ-012 SHALL have port fault, output, 1 bit, the OR of fault_status bits.
REQ-013 SHALL have port warn, output, 1 bit, the OR of (filtered warn AND NOT fault_mask).
REQ-014 SHALL have port eoc, output, 1 bit, a one-cycle end-of-scan pulse.
REQ-015 SHALL have port pgood_bus, output, 32 bits, power-good status.
REQ-016 SHALL have port fault_status, output, 32 bits, sticky per-rail faults; bits at and above NumConverters are tied to 0.

Function
REQ-017 SHALL keep a scan counter of ceil(log2(NumConverters)) bits, minimum 1, that increments on each conv_done strobe and wraps from NumConverters-1 to 0.
REQ-018 SHALL treat a conv_done strobe arriving while the counter equals NumConverters-1 as scan end; when NumConverters=1, every conv_done strobe is a scan end.
REQ-019 SHALL register eoc high for exactly the one cycle following the scan-end clock edge, and hold it low otherwise.
REQ-020 SHALL sample fault_raw and warn_raw only on scan-end edges, and ignore them at all other times.
REQ-021 SHALL give each rail a 4-bit saturating fault-debounce counter: on scan end it increments (saturating at FaultDebounce) if fault_raw[i]=1, else it clears to 0.
REQ-022 SHALL hold filtered fault[i] = (counter == FaultDebounce), updated on the same edge that asserts eoc.
REQ-023 SHALL give each rail a warn-debounce counter and filtered warn that behave identically to REQ-021 and REQ-022 but use WarnDebounce; filtered warn is not sticky.
REQ-024 SHALL set fault_status[i] on any edge where filtered fault[i]=1 and fault_mask[i]=0.
REQ-025 SHALL, on fault_clear, clear each fault_status[i] whose filtered fault[i]=0, and leave set bits whose condition persists.
REQ-026 SHALL, on simultaneous set and clear of the same bit, leave the bit set.
REQ-027 SHALL set an internal valid flag on the first scan end after reset, and hold it until the next reset.
REQ-028 SHALL, when PgoodConfig=1, drive pgood_bus[i] = valid AND NOT fault_status[i] for i < NumConverters, with the remaining bits at 0.
REQ-029 SHALL, when PgoodConfig=0, drive pgood_bus[0] = valid AND (AND over all rails of NOT fault_status[i]), with pgood_bus[31:1] at 0.
REQ-030 SHALL not change fault_status when fault_mask changes, and SHALL only gate new sets with fault_mask.
REQ-031 SHALL take effect on fault_mask changes at the next clock edge, with no pipeline lag.

Reset
REQ-032 SHALL, on reset asserted at any time including mid-scan, asynchronously clear the scan counter, all debounce counters, filtered flags, fault_status, valid and eoc.
REQ-033 SHALL drive fault=0, warn=0, eoc=0, pgood_bus=0 and fault_status=0 while reset is held.
REQ-034 SHALL, after reset release, start the first scan at rail 0.

Verification
REQ-035 SHALL verify with NumConverters=4: 4 conv_done strobes with raw inputs all 0 -> eoc high exactly 1 cycle after the 4th strobe, pgood_bus[0] goes 0->1 at the same time, and fault=0.
REQ-036 SHALL verify with FaultDebounce=3: fault_raw[2]=1 for 3 consecutive scans -> fault_status=0x4 and fault=1 at the 3rd eoc; if fault_raw[2] drops during the 2nd scan, fault_status stays 0.
REQ-037 SHALL verify sticky behaviour: with fault_status[2]=1, raw cleared for 1 scan, then fault_clear -> fault_status=0 and pgood recovers; fault_clear while filtered fault persists -> bit stays 1.
REQ-038 SHALL verify masking: fault_mask=0x4 with fault_raw[2]=1 for 5 scans -> fault=0, warn=0 and fault_status=0.
REQ-039 SHALL verify bus mode: PgoodConfig=1, NumConverters=32, fault on rail 31 -> pgood_bus=0x7FFFFFFF.
REQ-040 SHALL verify reset mid-operation: reset pulsed after 2 of 4 strobes -> all outputs are 0, and the next 4 strobes produce a single eoc.
